// File: rtl/rx_fifo_arbiter.sv
// rx_fifo_arbiter: round-robin readout of four bit-serial rx FIFOs
// into one framed byte stream, with per-channel overflow recovery.
module rx_fifo_arbiter #(
  parameter int USE_W = 16,
  parameter int LEN_W = 11
) (
  input  logic               In_Clk,
  input  logic               In_Reset,
  input  logic [LEN_W-1:0]   In_Packet_Length,
  input  logic [3:0]         In_Ch_Enable,
  input  logic [4*USE_W-1:0] In_Fifo_Use,
  input  logic [3:0]         In_Fifo_Full,
  input  logic [3:0]         In_q,
  output logic [3:0]         Out_Fifo_Read_En,
  output logic [3:0]         Out_Fifo_rst,
  output logic [7:0]         Out_Data,
  output logic               Out_Valid,
  output logic               Out_Sync,
  output logic [1:0]         Out_Channel,
  output logic               Out_Busy,
  output logic [3:0]         Out_Overflow
);

  localparam int CNT_W = LEN_W + 3;
  localparam int CMP_W = USE_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         ch_q, ch_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         rcnt_q, rcnt_d;
  logic [1:0]         rch_q, rch_d;
  logic [3:0]         ovf_q, ovf_d;

  logic               cap_q;
  logic [2:0]         bcnt_q;
  logic [6:0]         shift_q;
  logic [7:0]         data_q;
  logic [LEN_W-1:0]   byte_q;

  logic [3:0]         elig;
  logic [CMP_W-1:0]   need;
  logic               gnt_ok;
  logic [1:0]         gnt_ch;
  logic               ovf_hit;
  logic [1:0]         ovf_sel;
  logic               start;
  logic [CNT_W-1:0]   last;
  logic               q_bit;
  logic [7:0]         byte_now;
  logic               valid;

  // Eligibility: enabled, not full, at least one whole packet stored
  always_comb begin
    need = CMP_W'({In_Packet_Length, 3'b000});
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = In_Ch_Enable[i] & ~In_Fifo_Full[i]
              & (In_Packet_Length != '0)
              & (CMP_W'(In_Fifo_Use[USE_W*i +: USE_W]) >= need);
    end
  end

  // Round-robin pick: first eligible channel at or above the pointer
  always_comb begin
    logic [1:0] idx;
    gnt_ok = 1'b0;
    gnt_ch = ptr_q;
    idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        gnt_ok = 1'b1;
        gnt_ch = idx;
      end
    end
  end

  // Lowest enabled channel reporting full gets the recovery pulse
  always_comb begin
    ovf_hit = |(In_Ch_Enable & In_Fifo_Full);
    ovf_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (In_Ch_Enable[i] & In_Fifo_Full[i]) ovf_sel = 2'(i);
    end
  end

  // Control FSM next state: grant, count read requests, drain
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    rch_d   = rch_q;
    ovf_d   = ovf_q;
    start   = 1'b0;
    last    = {len_q, 3'b000} - CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (rcnt_q != 2'd0) begin
          rcnt_d = rcnt_q - 2'd1;
        end else if (ovf_hit) begin
          rcnt_d         = 2'd2;
          rch_d          = ovf_sel;
          ovf_d[ovf_sel] = 1'b1;
        end else if (gnt_ok) begin
          state_d = S_READ;
          ch_d    = gnt_ch;
          len_d   = In_Packet_Length;
          cnt_d   = '0;
          start   = 1'b1;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        ptr_d   = ch_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control FSM registers
  always_ff @(posedge In_Clk or negedge In_Reset) begin
    if (!In_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      ch_q    <= 2'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      rcnt_q  <= 2'd0;
      rch_q   <= 2'd0;
      ovf_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rch_q   <= rch_d;
      ovf_q   <= ovf_d;
    end
  end

  // Eighth captured bit completes a byte in the same cycle
  always_comb begin
    q_bit    = In_q[ch_q];
    byte_now = {shift_q, q_bit};
    valid    = cap_q & (bcnt_q == 3'd7);
  end

  // Bit capture, MSB-first packing and byte index
  always_ff @(posedge In_Clk or negedge In_Reset) begin
    if (!In_Reset) begin
      cap_q   <= 1'b0;
      bcnt_q  <= 3'd0;
      shift_q <= 7'd0;
      data_q  <= 8'd0;
      byte_q  <= '0;
    end else begin
      cap_q <= (state_q == S_READ);
      if (start) begin
        bcnt_q <= 3'd0;
        byte_q <= '0;
      end else if (cap_q) begin
        shift_q <= {shift_q[5:0], q_bit};
        bcnt_q  <= bcnt_q + 3'd1;
        if (valid) begin
          data_q <= byte_now;
          byte_q <= byte_q + LEN_W'(1);
        end
      end
    end
  end

  // Output decode
  always_comb begin
    Out_Fifo_Read_En = (state_q == S_READ) ? (4'b0001 << ch_q) : 4'b0000;
    Out_Fifo_rst     = (rcnt_q != 2'd0) ? (4'b0001 << rch_q) : 4'b0000;
    Out_Data         = valid ? byte_now : data_q;
    Out_Valid        = valid;
    Out_Sync         = valid & (byte_q == '0);
    Out_Channel      = ch_q;
    Out_Busy         = (state_q != S_IDLE);
    Out_Overflow     = ovf_q;
  end

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// tb_rx_fifo_arbiter: directed checks of grant order, framing,
// thresholds, overflow recovery and reset abort.
module tb_rx_fifo_arbiter;

  localparam int USE_W = 16;
  localparam int LEN_W = 11;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LEN_W-1:0]   len;
  logic [3:0]         en;
  logic [4*USE_W-1:0] use_v;
  logic [3:0]         full;
  logic [3:0]         q;
  logic [3:0]         rden;
  logic [3:0]         frst;
  logic [7:0]         data;
  logic               valid;
  logic               sync;
  logic [1:0]         chan;
  logic               busy;
  logic [3:0]         ovf;
  logic [24:0]        all_o;

  int n_chk = 0;
  int n_fail = 0;
  int exp_idx[4];
  int bitpos[4];

  rx_fifo_arbiter #(.USE_W(USE_W), .LEN_W(LEN_W)) dut (
    .In_Clk           (clk),
    .In_Reset         (rst_n),
    .In_Packet_Length (len),
    .In_Ch_Enable     (en),
    .In_Fifo_Use      (use_v),
    .In_Fifo_Full     (full),
    .In_q             (q),
    .Out_Fifo_Read_En (rden),
    .Out_Fifo_rst     (frst),
    .Out_Data         (data),
    .Out_Valid        (valid),
    .Out_Sync         (sync),
    .Out_Channel      (chan),
    .Out_Busy         (busy),
    .Out_Overflow     (ovf)
  );

  assign all_o = {rden, frst, data, valid, sync, chan, busy, ovf};

  always #5 clk = ~clk;

  function automatic logic [7:0] gen(int ch, int k);
    if (ch == 1 && k == 0) return 8'hA5;
    if (ch == 1 && k == 1) return 8'h3C;
    return 8'((ch * 37 + k * 29 + 3) & 255);
  endfunction

  function automatic logic gbit(int ch, int p);
    logic [7:0] b;
    b = gen(ch, p / 8);
    return b[7 - (p % 8)];
  endfunction

  // FIFO model: q follows a read request by one cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
      for (int i = 0; i < 4; i++) bitpos[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rden[i]) begin
          q[i]      <= gbit(i, bitpos[i]);
          bitpos[i] <= bitpos[i] + 1;
        end
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_use(int ch, int val);
    use_v[USE_W*ch +: USE_W] = USE_W'(val);
  endtask

  task automatic no_grant(int n, string tag);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (busy || rden != 4'd0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic pkt(int ch, int L, int maxw, logic [3:0] nen,
                     logic [LEN_W-1:0] nlen, logic [3:0] nfull);
    int w;
    bit got;
    logic vld;
    logic [8:0] ev;
    w = 0;
    got = 1'b0;
    while (w < maxw && !got) begin
      @(negedge clk);
      w++;
      if (busy) got = 1'b1;
      else chk("idle_valid", 32'(valid), 32'd0);
    end
    chk("grant", {got, chan}, {1'b1, 2'(ch)});
    if (got) begin
      en = nen;
      len = nlen;
      full = nfull;
      for (int c = 1; c <= 8 * L + 1; c++) begin
        if (c > 1) @(negedge clk);
        vld = (c >= 9) && ((c - 9) % 8 == 0);
        ev = {1'b1, 2'(ch), (c <= 8 * L) ? 4'(1 << ch) : 4'b0000,
              vld, (c == 9)};
        chk("pkt_ctl", {busy, chan, rden, valid, sync}, ev);
        if (vld) chk("pkt_byte", data, gen(ch, exp_idx[ch] + (c - 9) / 8));
      end
      exp_idx[ch] += L;
      @(negedge clk);
      chk("pkt_end", {busy, rden, valid}, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_idx[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    en = 4'd0;
    full = 4'd0;
    len = '0;
    use_v = '0;
    for (int i = 0; i < 4; i++) exp_idx[i] = 0;
    #1;
    chk("reset_outs", all_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single channel 1, L=10
    len = 11'd10;
    set_use(1, 80);
    en = 4'b0010;
    pkt(1, 10, 4, 4'b0000, 11'd10, 4'b0000);
    no_grant(10, "ch1_disabled");

    // round robin after reset
    do_reset();
    len = 11'd2;
    for (int i = 0; i < 4; i++) set_use(i, 16);
    en = 4'b1111;
    pkt(0, 2, 3, 4'b1111, 11'd2, 4'b0000);
    pkt(1, 2, 1, 4'b1111, 11'd2, 4'b0000);
    pkt(2, 2, 1, 4'b1111, 11'd2, 4'b0000);
    pkt(3, 2, 1, 4'b1111, 11'd2, 4'b0000);
    pkt(0, 2, 1, 4'b0000, 11'd2, 4'b0000);

    // threshold
    use_v = '0;
    set_use(2, 15);
    en = 4'b0100;
    no_grant(20, "thr_below");
    set_use(2, 16);
    pkt(2, 2, 1, 4'b0000, 11'd2, 4'b0000);

    // zero length
    len = '0;
    use_v = '1;
    en = 4'b1111;
    no_grant(30, "len_zero");
    en = 4'b0000;

    // overflow on ch3 while ch0 is mid-packet
    len = 11'd2;
    use_v = '0;
    set_use(0, 16);
    en = 4'b1001;
    pkt(0, 2, 3, 4'b1001, 11'd2, 4'b1000);
    @(negedge clk);
    chk("ovf_rst1", {frst, ovf, busy}, {4'b1000, 4'b1000, 1'b0});
    @(negedge clk);
    chk("ovf_rst2", {frst, busy}, {4'b1000, 1'b0});
    @(negedge clk);
    chk("ovf_rst3", {frst, busy}, 32'd0);
    set_use(3, 16);
    no_grant(12, "full_no_grant");
    en = 4'b0000;
    full = 4'b0000;
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {ovf, frst}, {4'b1000, 4'b0000});

    // mid-packet enable/length changes
    use_v = '0;
    set_use(1, 16);
    len = 11'd2;
    en = 4'b0010;
    pkt(1, 2, 3, 4'b0000, 11'd1, 4'b0000);
    en = 4'b0010;
    pkt(1, 1, 2, 4'b0000, 11'd1, 4'b0000);

    // reset abort at byte 3 of an L=8 packet
    use_v = '0;
    set_use(0, 64);
    len = 11'd8;
    en = 4'b0001;
    got = 1'b0;
    for (int w = 0; w < 3 && !got; w++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
    end
    chk("abort_grant", {got, chan}, {1'b1, 2'd0});
    repeat (32) @(negedge clk);
    chk("abort_byte3", {valid, sync, data},
        {1'b1, 1'b0, gen(0, exp_idx[0] + 3)});
    rst_n = 1'b0;
    #1;
    chk("abort_outs", all_o, 32'd0);
    en = 4'b0000;
    for (int i = 0; i < 4; i++) exp_idx[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_release", {valid, busy}, 32'd0);
    len = 11'd2;
    for (int i = 0; i < 4; i++) set_use(i, 16);
    en = 4'b1111;
    pkt(0, 2, 2, 4'b0000, 11'd2, 4'b0000);
    no_grant(5, "abort_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_fifo_arbiter.md
# rx_fifo_arbiter

Round-robin readout arbiter for the receive path. It shares one byte-stream output between four bit-serial input FIFOs: RCL, RCH, RDAC and ROMR, in channel order 0..3, with 1-bit q and no show-ahead. When a channel holds at least one full packet, the arbiter grants that channel, reads exactly one packet of bits MSB-first and packs them into bytes. It then emits the bytes with sync/valid framing and a channel tag. It also handles FIFO overflow recovery for each channel. It replaces single-channel FIFO reading in the Rx data path and runs entirely in the read-side clock domain.

## Interface
Parameters:
- USE_W, 16, width of each FIFO read-side used-words count.
- LEN_W, 11, width of packet length in bytes.

Ports:
- In_Clk  in  1  read-side clock (10 MHz domain); single clock for the block.
- In_Reset  in  1  asynchronous, active-low reset.
- In_Packet_Length  in  LEN_W  payload bytes per packet; sampled at grant.
- In_Ch_Enable  in  4  per-channel enable mask.
- In_Fifo_Use  in  4*USE_W  read-side used bits; channel i occupies [USE_W*i +: USE_W].
- In_Fifo_Full  in  4  write-side full flag per channel.
- In_q  in  4  FIFO data bit per channel; valid one cycle after the read request.
- Out_Fifo_Read_En  out  4  read request; at most one bit is high.
- Out_Fifo_rst  out  4  FIFO aclr pulse per channel.
- Out_Data  out  8  packed byte.
- Out_Valid  out  1  Out_Data qualifier; high for one cycle per byte.
- Out_Sync  out  1  high together with the first Out_Valid of each packet.
- Out_Channel  out  2  granted channel; stable for the whole packet.
- Out_Busy  out  1  high from grant until the last byte is emitted.
- Out_Overflow  out  4  sticky overflow flag per channel.

## Operation
- Reset (In_Reset=0): all outputs are 0. State is IDLE. The round-robin pointer is set to channel 0. The Out_Overflow flags are cleared only by reset.
- Eligibility of channel i: In_Ch_Enable[i]=1, In_Fifo_Full[i]=0, and In_Fifo_Use[i] >= 8*In_Packet_Length. The comparison is done at USE_W+3 bits with no truncation.
- If In_Packet_Length=0, no channel is eligible.
- IDLE:
  - If any enabled channel has its full flag set, the lowest such channel i gets Out_Fifo_rst[i] high for 2 cycles and Out_Overflow[i] set to 1. The block then stays in IDLE; no grant is made in those cycles.
  - Otherwise, if a channel is eligible, grant the first eligible channel starting at the pointer and moving upward with wrap 3→0. Latch the channel number and the length, then go to READ.
- READ: Out_Fifo_Read_En[ch] is held high for exactly 8*L consecutive cycles. A bit counter of width LEN_W+3 counts the requests.
- DRAIN: one cycle to capture the final bit, then go to IDLE. The pointer moves to ch+1 mod 4.
- Packing:
  - Each captured In_q[ch] bit is shifted into the byte register MSB-first.
  - Every 8th captured bit loads Out_Data and pulses Out_Valid.
  - The byte index counts 0..L-1; Out_Sync is set at index 0.
- Changes to In_Ch_Enable, In_Packet_Length or In_Fifo_Full during READ or DRAIN are ignored until IDLE. A packet in progress is always completed.
- Out_Fifo_rst is never asserted to the granted channel while Out_Busy=1.
- An asynchronous reset during a packet aborts it immediately. No partial byte is emitted after reset is released.

## Timing
- Grant cycle T is the IDLE cycle in which the channel is selected.
- Out_Busy and Out_Channel are valid from T+1.
- Out_Fifo_Read_En[ch] is high in cycles T+1 .. T+8L.
- In_q is sampled in cycles T+2 .. T+8L+1.
- Byte j: Out_Valid is high in cycle T+9+8j for j=0..L-1. Out_Sync is high only in cycle T+9.
- Out_Busy falls after cycle T+8L+1, which is the final Out_Valid cycle.
- IDLE evaluates again in cycle T+8L+2, so the minimum gap between packets is one cycle.
- Each packet takes 8L+2 cycles including the grant cycle. Throughput is one byte per 8 cycles within a packet.
- Out_Data holds its value between valids. Out_Valid and Out_Sync are single-cycle pulses.

## Test plan
- Single channel: reset, then enable only ch1 with Use=80 and L=10. Required:
  - Out_Fifo_Read_En=4'b0010 for 80 cycles.
  - 10 Out_Valid pulses spaced by 8 cycles; Out_Sync on the first; Out_Channel=1.
  - Bit stream 0xA5,0x3C... rebuilds exactly MSB-first.
- Round-robin: all four channels enabled and eligible, L=2. Required:
  - Grant order 0,1,2,3,0.
  - Each packet has 2 valids; packets are separated by exactly 1 idle cycle.
- Threshold: ch2 with Use=15 and L=2, so not eligible and no grant. Use rises to 16 → grant in the next IDLE cycle. L=0 with Use=max → no grant ever.
- Overflow: In_Fifo_Full[3]=1 while ch0 is mid-packet. Required:
  - ch0 packet completes with L valids.
  - Then Out_Fifo_rst=4'b1000 for 2 cycles and Out_Overflow[3]=1 (sticky).
  - Ch3 is not granted while full.
- Mid-packet changes: deassert In_Ch_Enable[ch] and change L during READ. The current packet still emits the original L bytes; the new L applies at the next grant.
- Reset abort: assert In_Reset=0 at byte 3 of an L=8 packet. All outputs go to 0 asynchronously. After release, no stray Out_Valid appears and the pointer restarts at ch0.
